// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default data-memory widths, the store-buffer entry
// record and the buffer occupancy classes.
package cpu_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } sb_occ_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer entries for load forwarding.
// Entries are visited oldest to youngest starting at head, so the last match wins.
module sb_fwd_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][AW-1:0] addrs,
   input  logic [DEPTH-1:0]         valid,
   input  logic [PW-1:0]            head,
   input  logic [AW-1:0]            ld_addr,
   output logic                     hit,
   output logic [PW-1:0]            index
);

   logic [PW-1:0] slot_s;
   logic          match_s;

   // Age-ordered scan: a younger match overrides any older one.
   always_comb begin
      hit     = 1'b0;
      index   = {PW{1'b0}};
      slot_s  = head;
      match_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         slot_s  = head + PW'(k);
         match_s = valid[slot_s] & (addrs[slot_s] == ld_addr);
         hit     = hit | match_s;
         index   = match_s ? slot_s : index;
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between core and data memory: in-order drain to memory
// and youngest-entry forwarding to loads.
module store_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    st_valid,
   input  logic [AW-1:0]           st_addr,
   input  logic [DW-1:0]           st_data,
   output logic                    st_ready,
   input  logic [AW-1:0]           ld_addr,
   output logic [DW-1:0]           ld_data,
   output logic                    ld_hit,
   input  logic                    drain_en,
   output logic                    mem_we,
   output logic [AW-1:0]           mem_a,
   output logic [DW-1:0]           mem_wd,
   input  logic [DW-1:0]           mem_rd,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   sb_entry_t                entry_r [DEPTH];
   logic [PW-1:0]            head_r;
   logic [PW-1:0]            tail_r;
   logic [CW-1:0]            count_r;
   logic [DEPTH-1:0]         valid_r;
   sb_occ_t                  occ_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     hit_s;
   logic [PW-1:0]            hit_idx_s;
   logic [DEPTH-1:0][AW-1:0] addrs_s;

   // Occupancy class decoded from the entry count.
   always_comb begin
      occ_s = OCC_PARTIAL;
      if (count_r == {CW{1'b0}}) begin
         occ_s = OCC_EMPTY;
      end else if (count_r == FULL_CNT) begin
         occ_s = OCC_FULL;
      end else begin
         occ_s = OCC_PARTIAL;
      end
   end

   assign push_s = st_valid & (occ_s != OCC_FULL);
   assign pop_s  = drain_en & (occ_s != OCC_EMPTY);

   // Head/tail pointers, occupancy count and per-entry valid mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         valid_r <= {DEPTH{1'b0}};
      end else begin
         if (push_s) begin
            tail_r          <= tail_r + PW'(1'b1);
            valid_r[tail_r] <= 1'b1;
         end
         // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
         if (pop_s) begin
            head_r          <= head_r + PW'(1'b1);
            valid_r[head_r] <= 1'b0;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry payload storage; occupancy is tracked by valid_r so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         entry_r[tail_r].addr <= st_addr;
         entry_r[tail_r].data <= st_data;
      end
   end

   // Flatten entry addresses for the match search.
   always_comb begin
      addrs_s = {(DEPTH*AW){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         addrs_s[i] = entry_r[i].addr;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PW    (PW)
   ) u_fwd_match (
      .addrs   (addrs_s),
      .valid   (valid_r),
      .head    (head_r),
      .ld_addr (ld_addr),
      .hit     (hit_s),
      .index   (hit_idx_s)
   );

   assign st_ready = (occ_s != OCC_FULL);
   assign mem_we   = pop_s;
   assign mem_a    = entry_r[head_r].addr;
   assign mem_wd   = entry_r[head_r].data;
   assign ld_hit   = hit_s;
   assign ld_data  = hit_s ? entry_r[hit_idx_s].data : mem_rd;
   assign count    = count_r;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model and a reference memory image.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk;
   logic          rst_n;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_ready;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_hit;
   logic          drain_en;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;
   logic [2:0]    count;

   int errors = 0;
   int checks = 0;

   // Data memory driven by the DUT, and the image the specification predicts.
   logic [DW-1:0] mem     [0:31];
   logic [DW-1:0] ref_mem [0:31];
   // Pending stores, oldest first, as {addr, data}.
   logic [AW+DW-1:0] q[$];

   assign mem_rd = mem[ld_addr];

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_ready (st_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_hit   (ld_hit),
      .drain_en (drain_en),
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic m_hit(input logic [AW-1:0] a);
      m_hit = 1'b0;
      foreach (q[i]) if (q[i][AW+DW-1:DW] == a) m_hit = 1'b1;
   endfunction

   // Later queue entries are younger, so the last match is the forwarded value.
   function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
      m_data = ref_mem[a];
      foreach (q[i]) if (q[i][AW+DW-1:DW] == a) m_data = q[i][DW-1:0];
   endfunction

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic dr, input logic [AW-1:0] la);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      drain_en = dr;
      ld_addr  = la;
      #1;
   endtask

   // Advance one clock edge, updating the memory and the reference model.
   task automatic tick();
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            do_pop;
      bit            do_push;
      we      = mem_we;
      a       = mem_a;
      d       = mem_wd;
      do_pop  = drain_en && (q.size() > 0);
      do_push = st_valid && (q.size() < DEPTH);
      @(posedge clk);
      if (we) mem[a] = d;
      if (do_pop) begin
         ref_mem[q[0][AW+DW-1:DW]] = q[0][DW-1:0];
         q.delete(0);
      end
      if (do_push) q.push_back({st_addr, st_data});
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      st_valid = 1'b0;
      drain_en = 1'b0;
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_forward();
      apply_reset();
      drive(1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL fwd_count got=%0d exp=1", count); end
      checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit got=%b exp=1", ld_hit); end
      checks++; if (ld_data !== 32'hAAAA5555) begin errors++; $display("FAIL fwd_data got=%h exp=aaaa5555", ld_data); end
   endtask

   task automatic test_youngest();
      apply_reset();
      drive(1'b1, 5'd7, 32'd1, 1'b0, 5'd7);
      tick();
      drive(1'b1, 5'd7, 32'd2, 1'b0, 5'd7);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7);
      checks++; if (ld_data !== 32'd2 || ld_hit !== 1'b1) begin errors++; $display("FAIL young_fwd got=%0d/%b exp=2/1", ld_data, ld_hit); end
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      checks++; if (mem_we !== 1'b1 || mem_a !== 5'd7 || mem_wd !== 32'd1) begin errors++; $display("FAIL young_drain1 got=%b/%0d/%0d exp=1/7/1", mem_we, mem_a, mem_wd); end
      checks++; if (ld_data !== 32'd2) begin errors++; $display("FAIL young_fwd_drain got=%0d exp=2", ld_data); end
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      checks++; if (mem_we !== 1'b1 || mem_a !== 5'd7 || mem_wd !== 32'd2) begin errors++; $display("FAIL young_drain2 got=%b/%0d/%0d exp=1/7/2", mem_we, mem_a, mem_wd); end
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      checks++; if (mem[7] !== 32'd2 || count !== 3'd0 || ld_hit !== 1'b0 || ld_data !== 32'd2) begin errors++; $display("FAIL young_final got=mem%0d cnt%0d hit%b ld%0d exp=2/0/0/2", mem[7], count, ld_hit, ld_data); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL young_empty_we got=%b exp=0", mem_we); end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, AW'(i + 1), $urandom, 1'b0, 5'd0);
         tick();
      end
      drive(1'b1, 5'd20, 32'hDEADBEEF, 1'b0, 5'd20);
      checks++; if (count !== 3'd4 || st_ready !== 1'b0) begin errors++; $display("FAIL full_state got=%0d/%b exp=4/0", count, st_ready); end
      tick();
      drive(1'b1, 5'd21, 32'hCAFE0000, 1'b1, 5'd20);
      checks++; if (count !== 3'd4 || ld_hit !== 1'b0 || ld_data !== ref_mem[20]) begin errors++; $display("FAIL full_ignored got=%0d/%b/%h exp=4/0/%h", count, ld_hit, ld_data, ref_mem[20]); end
      checks++; if (st_ready !== 1'b0 || mem_we !== 1'b1 || mem_a !== 5'd1) begin errors++; $display("FAIL full_pop_noready got=%b/%b/%0d exp=0/1/1", st_ready, mem_we, mem_a); end
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd21);
      checks++; if (st_ready !== 1'b1 || count !== 3'd3 || ld_hit !== 1'b0) begin errors++; $display("FAIL full_after_drain got=%b/%0d/%b exp=1/3/0", st_ready, count, ld_hit); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] la;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, AW'($urandom_range(0, 7)), $urandom, 1'b0, 5'd0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         la = AW'($urandom_range(0, 7));
         drive(1'b1, AW'($urandom_range(0, 7)), $urandom, 1'b1, la);
         checks++; if (count !== 3'd2 || mem_we !== 1'b1) begin errors++; $display("FAIL b2b_count i=%0d got=%0d/%b exp=2/1", i, count, mem_we); end
         checks++; if ({mem_a, mem_wd} !== q[0]) begin errors++; $display("FAIL b2b_head i=%0d got=%0d/%h exp=%h", i, mem_a, mem_wd, q[0]); end
         checks++; if (ld_data !== m_data(la) || ld_hit !== m_hit(la)) begin errors++; $display("FAIL b2b_ld i=%0d got=%h/%b exp=%h/%b", i, ld_data, ld_hit, m_data(la), m_hit(la)); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, AW'(10 + i), $urandom, 1'b0, 5'd0);
         tick();
      end
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      checks++; if (count !== 3'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_now got=%0d/%b exp=0/0", count, mem_we); end
      checks++; if (st_ready !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%b/%b exp=1/0", st_ready, ld_hit); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b1, AW'(10 + i));
         checks++; if (mem_we !== 1'b0 || ld_data !== ref_mem[10 + i]) begin errors++; $display("FAIL rstmid_after i=%0d got=%b/%h exp=0/%h", i, mem_we, ld_data, ref_mem[10 + i]); end
         tick();
      end
      for (int i = 10; i < 13; i++) begin
         checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rstmid_mem a=%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
      end
   endtask

   task automatic test_same_cycle();
      apply_reset();
      mem[9]     = 32'h34;
      ref_mem[9] = 32'h34;
      drive(1'b1, 5'd9, 32'h12, 1'b0, 5'd9);
      checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h34) begin errors++; $display("FAIL same_push got=%b/%h exp=0/34", ld_hit, ld_data); end
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h12) begin errors++; $display("FAIL same_next got=%b/%h exp=1/12", ld_hit, ld_data); end
   endtask

   task automatic test_random();
      logic [AW-1:0] la;
      logic          dr;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         la = AW'($urandom_range(0, 7));
         dr = ($urandom_range(0, 99) < 45);
         drive($urandom_range(0, 99) < 55, AW'($urandom_range(0, 7)), $urandom, dr, la);
         checks++; if (count !== 3'(q.size()) || st_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_occ i=%0d got=%0d/%b exp=%0d", i, count, st_ready, q.size()); end
         checks++; if (mem_we !== (dr && q.size() > 0)) begin errors++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, mem_we, dr && q.size() > 0); end
         if (dr && q.size() > 0) begin
            checks++; if ({mem_a, mem_wd} !== q[0]) begin errors++; $display("FAIL rnd_head i=%0d got=%0d/%h exp=%h", i, mem_a, mem_wd, q[0]); end
         end
         checks++; if (ld_hit !== m_hit(la) || ld_data !== m_data(la)) begin errors++; $display("FAIL rnd_ld i=%0d a=%0d got=%b/%h exp=%b/%h", i, la, ld_hit, ld_data, m_hit(la), m_data(la)); end
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
         tick();
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rnd_drained got=%0d exp=0", count); end
      for (int a = 0; a < 32; a++) begin
         checks++; if (mem[a] !== ref_mem[a]) begin errors++; $display("FAIL rnd_mem a=%0d got=%h exp=%h", a, mem[a], ref_mem[a]); end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      st_valid = 1'b0;
      st_addr  = 5'd0;
      st_data  = 32'd0;
      drain_en = 1'b0;
      ld_addr  = 5'd0;
      for (int a = 0; a < 32; a++) begin
         mem[a]     = $urandom;
         ref_mem[a] = mem[a];
      end
      test_reset();
      test_forward();
      test_youngest();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_same_cycle();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, 2..16).
REQ-002 SHALL have parameter AW, default 5, data-memory word-address width.
REQ-003 SHALL have parameter DW, default 32, data word width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port st_valid  input  1  core presents a store this cycle.
REQ-007 SHALL have port st_addr  input  AW  store word address.
REQ-008 SHALL have port st_data  input  DW  store data.
REQ-009 SHALL have port st_ready  output  1  buffer can accept a store.
REQ-010 SHALL have port ld_addr  input  AW  load word address from core.
REQ-011 SHALL have port ld_data  output  DW  load result to core (forwarded or memory).
REQ-012 SHALL have port ld_hit  output  1  ld_data sourced from buffer.
REQ-013 SHALL have port drain_en  input  1  data memory may be written this cycle.
REQ-014 SHALL have port mem_we  output  1  write enable to data memory WE.
REQ-015 SHALL have port mem_a  output  AW  address to data memory A.
REQ-016 SHALL have port mem_wd  output  DW  write data to data memory WD.
REQ-017 SHALL have port mem_rd  input  DW  read data from data memory RD (combinational read at ld_addr).
REQ-018 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL be a circular FIFO of DEPTH entries {addr, data}, head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL use occupancy states EMPTY (count=0), PARTIAL, FULL (count=DEPTH), derived from count.
REQ-021 SHALL drive st_ready = (count != DEPTH); a push occurs at clock edge iff st_valid & st_ready.
REQ-022 SHALL drive mem_we = (count != 0) & drain_en; mem_a/mem_wd = head entry, combinationally.
REQ-023 SHALL pop the head at the same edge the memory samples mem_we=1 (one store per cycle, latency from push to mem_we >= 1 cycle).
REQ-024 SHALL on simultaneous push and pop keep count unchanged; FULL with pop still rejects push (st_ready low).
REQ-025 SHALL write stores to memory strictly in push order; no coalescing or reordering.
REQ-026 SHALL set ld_hit when any occupied entry matches ld_addr, and drive ld_data from the youngest matching entry; else ld_data = mem_rd, ld_hit = 0.
REQ-027 SHALL treat the head entry being drained this cycle as still occupied for forwarding.
REQ-028 SHALL not forward a store being pushed in the same cycle; it becomes visible from the next cycle.
REQ-029 SHALL ignore st_valid when st_ready is low (core must hold and retry); ld path is purely combinational.

Reset
REQ-030 SHALL on rst_n low, asynchronously, clear head, tail, count and all entry-valid state; outputs become st_ready=1, mem_we=0, ld_hit=0, count=0.
REQ-031 SHALL discard pending stores on reset mid-operation; entry addr/data storage need not be reset.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL take AW, DW defaults and the entry record type from shared package cpu_pkg.
REQ-034 SHALL place youngest-match priority logic in one sub-module sb_fwd_match (inputs: entry addrs, valid mask, age order, ld_addr; outputs: hit, index).
REQ-035 SHALL connect mem_we/mem_a/mem_wd/mem_rd directly to data memory WE/A/WD/RD with no extra pipeline stage.

Verification
REQ-036 SHALL test: reset, push (A=3,D=0xAAAA5555) with drain_en=0 -> count=1, ld_addr=3 gives ld_hit=1, ld_data=0xAAAA5555.
REQ-037 SHALL test: push A=7 D=1 then A=7 D=2, drain_en=0 -> ld_addr=7 returns 2 (youngest); enable drain -> memory writes 1 then 2 in order.
REQ-038 SHALL test: 4 pushes with drain_en=0 -> count=4, st_ready=0; 5th st_valid ignored; one drain -> st_ready=1 next cycle.
REQ-039 SHALL test: count=2, push and drain same cycle -> count stays 2, pointers wrap correctly over 10 cycles of sustained traffic.
REQ-040 SHALL test: count=3, rst_n pulsed low mid-cycle -> count=0, mem_we=0 immediately; no pending store reaches memory.
REQ-041 SHALL test: push A=9 D=0x12 same cycle as ld_addr=9, memory holds 0x34 -> ld_data=0x34, ld_hit=0; next cycle ld_data=0x12, ld_hit=1.
